memory_game_ctrl: RTL

// - Game controller for the 4x4 memory (pairs) card game; sits upstream of the per-card VGA renderers.
// - Owns cursor, per-card face-up flags, match bookkeeping and the mismatch reveal timer.
// - face_up[i] drives the enable input of the card renderer at grid position i; cursor feeds the highlight overlay.
// - Grid position index is row*4+col (row 0 top, col 0 left), identical to the renderer pos encoding.

---
 rtl/memgame_pkg.sv | 37 +++
 rtl/memory_game_ctrl_btn_edge_det.sv | 31 +++
 rtl/memory_game_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/memgame_pkg.sv
// rtl/memgame_pkg.sv - shared constants, state encoding and card lookup for the memory game
package memgame_pkg;

    localparam int GRID_W    = 4;
    localparam int GRID_H    = 4;
    localparam int NUM_CARDS = 16;
    localparam int NUM_PAIRS = 8;
    localparam int CARD_W    = 3;

    // Bit positions of the buttons inside the edge detector vector
    localparam int BTN_SEL   = 0;
    localparam int BTN_UP    = 1;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_LEFT  = 3;
    localparam int BTN_RIGHT = 4;

    localparam logic [2:0] S_PICK1         = 3'd0;
    localparam logic [2:0] S_PICK2         = 3'd1;
    localparam logic [2:0] S_COMPARE       = 3'd2;
    localparam logic [2:0] S_SHOW_MISMATCH = 3'd3;
    localparam logic [2:0] S_DONE          = 3'd4;

    typedef enum logic [2:0] {
        PICK1         = S_PICK1,
        PICK2         = S_PICK2,
        COMPARE       = S_COMPARE,
        SHOW_MISMATCH = S_SHOW_MISMATCH,
        DONE          = S_DONE
    } state_t;

    // Card value at a grid position: three bits per card, position 0 in the LSBs
    function automatic logic [CARD_W-1:0] card_value(input logic [47:0] layout,
                                                     input logic [3:0]  pos);
        return layout[pos*CARD_W +: CARD_W];
    endfunction

endpackage

// File: rtl/memory_game_ctrl_btn_edge_det.sv
// rtl/memory_game_ctrl_btn_edge_det.sv - 5-bit rising-edge detector for the game buttons
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   level[4:0]   debounced button levels
//   pulse[4:0]   high in the first cycle each level is sampled high
module btn_edge_det (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] level,
    output logic [4:0] pulse
);

    logic [4:0] prev_q;
    logic [4:0] prev_d;

    always_comb begin
        prev_d = level;
    end

    // Combinational pulse so the action lands on the same edge the level is first seen
    assign pulse = level & ~prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/memory_game_ctrl.sv
// rtl/memory_game_ctrl.sv - 4x4 pairs game controller: cursor, picks, matching and reveal timer
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   btn_up/down/left/right     debounced levels, move cursor (wrapping)
//   btn_sel                    debounced level, flip card under cursor
//   new_game                   sync pulse, restart game
//   cursor[3:0]                grid position row*4+col
//   face_up[15:0]              per-card visible flag
//   pairs[3:0], attempts[7:0]  matched pairs, completed comparisons (saturating)
//   busy, game_done            COMPARE/SHOW_MISMATCH active, all pairs found
module memory_game_ctrl
    import memgame_pkg::*;
#(
    parameter logic [47:0] LAYOUT          = 48'h053977_FAC688,
    parameter int          MISMATCH_CYCLES = 25_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_sel,
    input  logic        new_game,
    output logic [3:0]  cursor,
    output logic [15:0] face_up,
    output logic [3:0]  pairs,
    output logic [7:0]  attempts,
    output logic        busy,
    output logic        game_done
);

    // A one-cycle reveal still needs a one-bit timer holding zero
    localparam int TIMER_W = (MISMATCH_CYCLES > 1) ? $clog2(MISMATCH_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(MISMATCH_CYCLES - 1);

    logic [4:0] pulse;

    btn_edge_det u_btn_edge_det (
        .clk   (clk),
        .rst_n (rst_n),
        .level ({btn_right, btn_left, btn_down, btn_up, btn_sel}),
        .pulse (pulse)
    );

    state_t             state_q, state_d;
    logic [3:0]         cursor_q, cursor_d;
    logic [3:0]         first_q, first_d;
    logic [3:0]         second_q, second_d;
    logic [15:0]        matched_q, matched_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [3:0]         pairs_q, pairs_d;
    logic [7:0]         attempts_q, attempts_d;
    logic [15:0]        face_up_q, face_up_d;
    logic               busy_q, busy_d;
    logic               game_done_q, game_done_d;

    logic               move_ok;

    always_comb begin
        state_d    = state_q;
        cursor_d   = cursor_q;
        first_d    = first_q;
        second_d   = second_q;
        matched_d  = matched_q;
        timer_d    = timer_q;
        pairs_d    = pairs_q;
        attempts_d = attempts_q;
        move_ok    = (state_q == PICK1) || (state_q == PICK2) || (state_q == SHOW_MISMATCH);

        if (new_game) begin
            state_d    = PICK1;
            cursor_d   = '0;
            first_d    = '0;
            second_d   = '0;
            matched_d  = '0;
            timer_d    = '0;
            pairs_d    = '0;
            attempts_d = '0;
        end else begin
            // A sel edge claims the cycle even when the selection itself is ignored
            if (pulse[BTN_SEL]) begin
                if (state_q == PICK1 && !face_up_q[cursor_q]) begin
                    first_d = cursor_q;
                    state_d = PICK2;
                end else if (state_q == PICK2 && !face_up_q[cursor_q]) begin
                    second_d = cursor_q;
                    state_d  = COMPARE;
                end
            end else if (move_ok) begin
                // Row lives in [3:2], column in [1:0]; 2-bit arithmetic gives the wrap
                if (pulse[BTN_UP]) begin
                    cursor_d = {cursor_q[3:2] - 2'd1, cursor_q[1:0]};
                end else if (pulse[BTN_DOWN]) begin
                    cursor_d = {cursor_q[3:2] + 2'd1, cursor_q[1:0]};
                end else if (pulse[BTN_LEFT]) begin
                    cursor_d = {cursor_q[3:2], cursor_q[1:0] - 2'd1};
                end else if (pulse[BTN_RIGHT]) begin
                    cursor_d = {cursor_q[3:2], cursor_q[1:0] + 2'd1};
                end
            end

            if (state_q == COMPARE) begin
                if (attempts_q != 8'hFF) begin
                    attempts_d = attempts_q + 8'd1;
                end
                if (card_value(LAYOUT, first_q) == card_value(LAYOUT, second_q)) begin
                    matched_d = matched_q | (16'd1 << first_q) | (16'd1 << second_q);
                    pairs_d   = pairs_q + 4'd1;
                    state_d   = (pairs_q == 4'(NUM_PAIRS - 1)) ? DONE : PICK1;
                end else begin
                    timer_d = TIMER_LOAD;
                    state_d = SHOW_MISMATCH;
                end
            end else if (state_q == SHOW_MISMATCH) begin
                if (timer_q == '0) begin
                    state_d = PICK1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
        end

        // Outputs are computed from next-state values so they register alongside it
        face_up_d = matched_d;
        if (state_d == PICK2 || state_d == COMPARE || state_d == SHOW_MISMATCH) begin
            face_up_d = face_up_d | (16'd1 << first_d);
        end
        if (state_d == COMPARE || state_d == SHOW_MISMATCH) begin
            face_up_d = face_up_d | (16'd1 << second_d);
        end
        if (state_d == DONE) begin
            face_up_d = 16'hFFFF;
        end
        busy_d      = (state_d == COMPARE) || (state_d == SHOW_MISMATCH);
        game_done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PICK1;
            cursor_q    <= '0;
            first_q     <= '0;
            second_q    <= '0;
            matched_q   <= '0;
            timer_q     <= '0;
            pairs_q     <= '0;
            attempts_q  <= '0;
            face_up_q   <= '0;
            busy_q      <= 1'b0;
            game_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cursor_q    <= cursor_d;
            first_q     <= first_d;
            second_q    <= second_d;
            matched_q   <= matched_d;
            timer_q     <= timer_d;
            pairs_q     <= pairs_d;
            attempts_q  <= attempts_d;
            face_up_q   <= face_up_d;
            busy_q      <= busy_d;
            game_done_q <= game_done_d;
        end
    end

    assign cursor    = cursor_q;
    assign face_up   = face_up_q;
    assign pairs     = pairs_q;
    assign attempts  = attempts_q;
    assign busy      = busy_q;
    assign game_done = game_done_q;

endmodule
